// File: rtl/mem_port_arbiter_if.sv
// Request, grant, memory and response signals between the two core requesters, the arbiter and the shared memory.
// The arbiter takes the slave view; the environment (core and memory) takes the master view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        rsp_err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one pipelined memory port between fetch and load/store; data has priority, fetch has a starvation guard.
// Latency: grant and response steering are combinational; owner tags and starvation count update at the clock edge.
// Backpressure: mem_gnt=0, or a full owner-tag FIFO for reads, withholds grants; requesters hold until granted.
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [MAX_OUTSTANDING-1:0] tag_mem;
  logic [SW-1:0]              starve_cnt;
  logic                       rsp_err_q;
  logic [IW-1:0]              wr_idx;
  logic [IW-1:0]              rd_idx;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       head_tag;
  logic                       if_elig;
  logic                       d_elig;
  logic                       sel_if;
  logic                       sel_d;
  logic                       push;
  logic                       pop;
  logic                       orphan;

  assign wr_idx     = (MAX_OUTSTANDING == 1) ? '0 : IW'(wr_ptr);
  assign rd_idx     = (MAX_OUTSTANDING == 1) ? '0 : IW'(rd_ptr);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = ((wr_ptr ^ rd_ptr) == (PW'(1) << (PW - 1)));
  assign head_tag   = tag_mem[rd_idx];

  // Eligibility uses registered occupancy, so a same-cycle pop never frees a slot early.
  assign if_elig = bus.if_req & ~fifo_full & ~rst;
  assign d_elig  = bus.d_req & (bus.d_we | ~fifo_full) & ~rst;

  always_comb begin
    sel_if = 1'b0;
    sel_d  = 1'b0;
    if (if_elig && d_elig) begin
      if (starve_cnt == SW'(STARVE_LIMIT)) sel_if = 1'b1;
      else                                 sel_d  = 1'b1;
    end else if (if_elig) begin
      sel_if = 1'b1;
    end else if (d_elig) begin
      sel_d = 1'b1;
    end
  end

  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'h0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    if (sel_d) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = bus.d_we;
      bus.mem_be    = bus.d_be;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end else if (sel_if) begin
      bus.mem_req  = 1'b1;
      bus.mem_be   = 4'hF;
      bus.mem_addr = bus.if_addr;
    end
  end

  assign bus.if_gnt = sel_if & bus.mem_gnt;
  assign bus.d_gnt  = sel_d & bus.mem_gnt;

  assign push   = bus.mem_req & bus.mem_gnt & ~bus.mem_we;
  assign pop    = bus.mem_rvalid & ~fifo_empty & ~rst;
  assign orphan = bus.mem_rvalid & fifo_empty & ~rst;

  assign bus.if_rvalid = pop & ~head_tag;
  assign bus.d_rvalid  = pop & head_tag;
  assign bus.if_rdata  = rst ? 32'h0 : bus.mem_rdata;
  assign bus.d_rdata   = rst ? 32'h0 : bus.mem_rdata;
  assign bus.rsp_err   = rsp_err_q & ~rst;

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_idx] <= sel_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (orphan) rsp_err_q <= 1'b1;
      if (!bus.if_req || bus.if_gnt)
        starve_cnt <= '0;
      else if (bus.d_gnt && starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations (MAX_OUTSTANDING=2, STARVE_LIMIT=4).
module tb_mem_port_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic prev_i;
  logic exp_i;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst            = 1'b1;
    bus.if_req     = 1'b1;
    bus.if_addr    = 32'h40;
    bus.d_req      = 1'b1;
    bus.d_we       = 1'b0;
    bus.d_be       = 4'h0;
    bus.d_addr     = 32'h200;
    bus.d_wdata    = 32'h0;
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;

    // Reset held with both requesting: nothing visible
    for (int r = 0; r < 2; r++) begin
      tick();
      chk_eq("rst_if_gnt", bus.if_gnt, 0);
      chk_eq("rst_d_gnt", bus.d_gnt, 0);
      chk_eq("rst_mem_req", bus.mem_req, 0);
      chk_eq("rst_d_rvalid", bus.d_rvalid, 0);
      chk_eq("rst_rsp_err", bus.rsp_err, 0);
    end

    // Continuous loads: D,D,D,D,I pattern, responses one cycle after each grant
    rst    = 1'b0;
    prev_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.mem_rvalid = (k > 0);
      bus.mem_rdata  = 32'hA000_0000 + k;
      #1;
      exp_i = (k % 5 == 4);
      chk_eq("pat_if_gnt", bus.if_gnt, exp_i);
      chk_eq("pat_d_gnt", bus.d_gnt, !exp_i);
      chk_eq("pat_addr", bus.mem_addr, exp_i ? 32'h40 : 32'h200);
      if (k > 0) begin
        chk_eq("pat_if_rvalid", bus.if_rvalid, prev_i);
        chk_eq("pat_d_rvalid", bus.d_rvalid, !prev_i);
        chk_eq("pat_rdata", bus.d_rdata, 32'hA000_0000 + k);
      end
      prev_i = exp_i;
      tick();
    end
    bus.if_req     = 1'b0;
    bus.d_req      = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555;
    #1;
    chk_eq("drain_if_rvalid", bus.if_rvalid, 1);
    chk_eq("drain_d_rvalid", bus.d_rvalid, 0);
    chk_eq("drain_if_rdata", bus.if_rdata, 32'h5555);
    chk_eq("drain_mem_req", bus.mem_req, 0);
    tick();

    // Fill the tag FIFO with two loads, then the third must wait
    bus.mem_rvalid = 1'b0;
    bus.if_req     = 1'b1;
    bus.d_req      = 1'b1;
    #1;
    chk_eq("full_gnt0", bus.d_gnt, 1);
    tick();
    chk_eq("full_gnt1", bus.d_gnt, 1);
    tick();
    chk_eq("full_if_gnt", bus.if_gnt, 0);
    chk_eq("full_d_gnt", bus.d_gnt, 0);
    chk_eq("full_mem_req", bus.mem_req, 0);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEADBEEF;
    #1;
    chk_eq("pop_d_rvalid", bus.d_rvalid, 1);
    chk_eq("pop_if_rvalid", bus.if_rvalid, 0);
    chk_eq("pop_d_rdata", bus.d_rdata, 32'hDEADBEEF);
    chk_eq("pop_same_cycle_req", bus.mem_req, 0);
    tick();
    bus.mem_rvalid = 1'b0;
    #1;
    chk_eq("after_pop_d_gnt", bus.d_gnt, 1);
    tick();

    // Store while full: granted, no tag pushed
    bus.d_we    = 1'b1;
    bus.d_be    = 4'b0011;
    bus.d_addr  = 32'h100;
    bus.d_wdata = 32'h12345678;
    #1;
    chk_eq("st_d_gnt", bus.d_gnt, 1);
    chk_eq("st_if_gnt", bus.if_gnt, 0);
    chk_eq("st_mem_we", bus.mem_we, 1);
    chk_eq("st_mem_be", bus.mem_be, 4'b0011);
    chk_eq("st_mem_addr", bus.mem_addr, 32'h100);
    chk_eq("st_mem_wdata", bus.mem_wdata, 32'h12345678);
    tick();
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    #1;
    chk_eq("st_no_push", bus.mem_req, 0);
    tick();
    bus.if_req     = 1'b0;
    bus.mem_rvalid = 1'b1;
    for (int p = 0; p < 2; p++) begin
      #1;
      chk_eq("st_drain_d_rvalid", bus.d_rvalid, 1);
      chk_eq("st_drain_if_rvalid", bus.if_rvalid, 0);
      tick();
    end
    bus.mem_rvalid = 1'b0;
    #1;
    chk_eq("st_rsp_err", bus.rsp_err, 0);
    tick();

    // Stall: counter at 3 must survive three mem_gnt=0 cycles
    bus.d_addr = 32'h200;
    bus.d_be   = 4'h0;
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    #1;
    chk_eq("stl_g1", bus.d_gnt, 1);
    tick();
    bus.mem_rvalid = 1'b1;
    #1;
    chk_eq("stl_g2", bus.d_gnt, 1);
    chk_eq("stl_rv2", bus.d_rvalid, 1);
    tick();
    #1;
    chk_eq("stl_g3", bus.d_gnt, 1);
    tick();
    bus.mem_gnt = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk_eq("stl_no_if_gnt", bus.if_gnt, 0);
      chk_eq("stl_no_d_gnt", bus.d_gnt, 0);
      tick();
      bus.mem_rvalid = 1'b0;
    end
    bus.mem_gnt = 1'b1;
    #1;
    chk_eq("stl_resume_d_gnt", bus.d_gnt, 1);
    chk_eq("stl_resume_if_gnt", bus.if_gnt, 0);
    tick();
    bus.mem_rvalid = 1'b1;
    #1;
    chk_eq("stl_force_if_gnt", bus.if_gnt, 1);
    chk_eq("stl_force_d_gnt", bus.d_gnt, 0);
    chk_eq("stl_force_addr", bus.mem_addr, 32'h40);
    chk_eq("stl_force_be", bus.mem_be, 4'hF);
    chk_eq("stl_force_we", bus.mem_we, 0);
    tick();
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    #1;
    chk_eq("stl_if_rvalid", bus.if_rvalid, 1);
    chk_eq("stl_d_rvalid", bus.d_rvalid, 0);
    tick();

    // Reset with two reads in flight: late responses are orphans
    bus.mem_rvalid = 1'b0;
    bus.if_req     = 1'b1;
    bus.d_req      = 1'b1;
    tick();
    tick();
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    rst        = 1'b1;
    tick();
    rst            = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE;
    #1;
    chk_eq("orph_if_rvalid", bus.if_rvalid, 0);
    chk_eq("orph_d_rvalid", bus.d_rvalid, 0);
    chk_eq("orph_err_pre", bus.rsp_err, 0);
    tick();
    bus.mem_rvalid = 1'b0;
    #1;
    chk_eq("orph_err_set", bus.rsp_err, 1);
    repeat (3) tick();
    chk_eq("orph_err_sticky", bus.rsp_err, 1);
    rst = 1'b1;
    tick();
    chk_eq("orph_err_rst", bus.rsp_err, 0);
    rst = 1'b0;
    tick();
    chk_eq("orph_err_cleared", bus.rsp_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
